// File: rtl/ctrl_pkg.sv
// Shared opcodes, controller states, accumulator-source codes and the
// EXEC control word for the accumulator CPU controller.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    DECODE,
    EXEC,
    HALT,
    FAULT
  } state_t;

  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b01;
  localparam logic [1:0] ACC_IMM = 2'b10;

  typedef struct packed {
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       load_pc;
    logic       sel_pc;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_fsm_mc_if.sv
// Controller <-> datapath/instruction-memory signal bundle. The controller
// takes the master side because it issues the fetch requests.
interface ctrl_fsm_mc_if #(
  parameter int OP_W  = 4,
  parameter int ALU_W = 4,
  parameter int CNT_W = 16
);
  logic [OP_W-1:0]  Opcode;
  logic             Z;
  logic             C;
  logic             mem_ready;
  logic             resume;
  logic             LoadIR;
  logic             IncPC;
  logic             SelPC;
  logic             LoadPC;
  logic             LoadReg;
  logic             LoadAcc;
  logic [1:0]       SelAcc;
  logic [ALU_W-1:0] SelALU;
  logic             mem_req;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Opcode, Z, C, mem_ready, resume,
    output LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
           mem_req, halted, fault, instr_count
  );

  modport slave (
    output Opcode, Z, C, mem_ready, resume,
    input  LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
           mem_req, halted, fault, instr_count
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational EXEC-cycle decode: low opcode nibble plus Z/C flags to the
// datapath control word.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic        z,
  input  logic        c,
  output ctrl_word_t  cw
);

  always_comb begin
    cw = '0;
    case (op)
      OP_LDA: begin
        cw.load_acc = 1'b1;
        cw.sel_acc  = ACC_REG;
      end
      OP_STA: cw.load_reg = 1'b1;
      OP_LDI: begin
        cw.load_acc = 1'b1;
        cw.sel_acc  = ACC_IMM;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        cw.load_acc = 1'b1;
        cw.sel_acc  = ACC_ALU;
        cw.sel_alu  = op;
      end
      OP_JMP: begin
        cw.load_pc = 1'b1;
        cw.sel_pc  = 1'b1;
      end
      OP_JZ: begin
        cw.load_pc = z;
        cw.sel_pc  = z;
      end
      OP_JC: begin
        cw.load_pc = c;
        cw.sel_pc  = c;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle FETCH/DECODE/EXEC controller with fetch timeout, HALT/resume,
// illegal-opcode fault and a wrapping retired-instruction counter.
module ctrl_fsm_mc
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ALU_W    = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          CLB,
  ctrl_fsm_mc_if.master bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic       illegal;
  logic       load_ir, inc_pc, mem_req, halted, fault;
  ctrl_word_t exec_cw, cw_out;

  // Opcode bits above the 4-bit field only exist when OP_W > 4.
  generate
    if (OP_W > 4) begin : g_wide_op
      assign illegal = |bus.Opcode[OP_W-1:4];
    end else begin : g_narrow_op
      assign illegal = 1'b0;
    end
  endgenerate

  ctrl_decode u_decode (
    .op (bus.Opcode[3:0]),
    .z  (bus.Z),
    .c  (bus.C),
    .cw (exec_cw)
  );

  always_ff @(posedge clk) begin
    if (!CLB) begin
      state_q    <= BOOT;
      wait_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    count_d    = count_q;
    load_ir    = 1'b0;
    inc_pc     = 1'b0;
    mem_req    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    cw_out     = '0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          load_ir    = 1'b1;
          inc_pc     = 1'b1;
          wait_cnt_d = '0;
          state_d    = DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        if (illegal)
          state_d = FAULT;
        else if (bus.Opcode[3:0] == OP_HLT)
          state_d = HALT;
        else
          state_d = EXEC;
      end
      EXEC: begin
        cw_out  = exec_cw;
        count_d = count_q + CNT_W'(1);
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (bus.resume)
          state_d = FETCH;
      end
      FAULT: fault = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  assign bus.LoadIR      = load_ir;
  assign bus.IncPC       = inc_pc;
  assign bus.SelPC       = cw_out.sel_pc;
  assign bus.LoadPC      = cw_out.load_pc;
  assign bus.LoadReg     = cw_out.load_reg;
  assign bus.LoadAcc     = cw_out.load_acc;
  assign bus.SelAcc      = cw_out.sel_acc;
  assign bus.SelALU      = ALU_W'(cw_out.sel_alu);
  assign bus.mem_req     = mem_req;
  assign bus.halted      = halted;
  assign bus.fault       = fault;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Self-checking bench for ctrl_fsm_mc: vector table, random instruction
// stream against an instruction-level model, and fault/halt/reset sequences.
module tb_ctrl_fsm_mc;

  localparam int OP_W     = 6;
  localparam int ALU_W    = 4;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic CLB;
  always #5 clk = ~clk;

  ctrl_fsm_mc_if #(.OP_W(OP_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) bus_if ();

  ctrl_fsm_mc #(
    .OP_W(OP_W), .ALU_W(ALU_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .CLB (CLB),
    .bus (bus_if)
  );

  typedef struct packed {
    logic       ir;
    logic       inc;
    logic       sel_pc;
    logic       load_pc;
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       mem_req;
    logic       halted;
    logic       fault;
  } outw_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       c;
    outw_t      exp;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int model_count = 0;
  vec_t vecs [18];

  function automatic outw_t sample();
    outw_t w;
    w.ir       = bus_if.LoadIR;
    w.inc      = bus_if.IncPC;
    w.sel_pc   = bus_if.SelPC;
    w.load_pc  = bus_if.LoadPC;
    w.load_reg = bus_if.LoadReg;
    w.load_acc = bus_if.LoadAcc;
    w.sel_acc  = bus_if.SelAcc;
    w.sel_alu  = bus_if.SelALU;
    w.mem_req  = bus_if.mem_req;
    w.halted   = bus_if.halted;
    w.fault    = bus_if.fault;
    return w;
  endfunction

  function automatic outw_t w_state(input bit mreq, input bit ldir,
                                    input bit hlt, input bit flt);
    outw_t w = '0;
    w.mem_req = mreq;
    w.ir      = ldir;
    w.inc     = ldir;
    w.halted  = hlt;
    w.fault   = flt;
    return w;
  endfunction

  // Hand-written EXEC pattern for the vector table.
  function automatic outw_t ex(input bit la, input bit [1:0] sa,
                               input bit [3:0] alu, input bit lr, input bit lp);
    outw_t w = '0;
    w.load_acc = la;
    w.sel_acc  = sa;
    w.sel_alu  = alu;
    w.load_reg = lr;
    w.load_pc  = lp;
    w.sel_pc   = lp;
    return w;
  endfunction

  // Reference model: EXEC strobes from the instruction-set rules.
  function automatic outw_t model_exec(input int op, input bit z, input bit c);
    outw_t w;
    bit is_alu;
    w = '0;
    is_alu     = (op >= 4) && (op <= 11);
    w.load_acc = (op == 1) || (op == 3) || is_alu;
    w.sel_acc  = (op == 1) ? 2'b01 : ((op == 3) ? 2'b10 : 2'b00);
    w.sel_alu  = is_alu ? 4'(op) : 4'd0;
    w.load_reg = (op == 2);
    w.load_pc  = (op == 12) || (op == 13 && z) || (op == 14 && c);
    w.sel_pc   = w.load_pc;
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string name, input outw_t exp);
    outw_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name);
    n_checks++;
    if (bus_if.instr_count !== CNT_W'(model_count)) begin
      n_errors++;
      $display("FAIL %s: instr_count got %0d expected %0d", name,
               bus_if.instr_count, model_count % (1 << CNT_W));
    end
  endtask

  // Starts in a FETCH cycle, ends in the next FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input bit z, input bit c,
                           input int nwait, input outw_t exp_exec,
                           input string tag);
    for (int i = 0; i < nwait; i++) begin
      bus_if.mem_ready = 1'b0;
      bus_if.Opcode    = 6'($urandom);
      bus_if.resume    = 1'($urandom);
      #1;
      check_w({tag, "/wait"}, w_state(1, 0, 0, 0));
      cyc();
    end
    bus_if.mem_ready = 1'b1;
    bus_if.Opcode    = op;
    #1;
    check_w({tag, "/fetch"}, w_state(1, 1, 0, 0));
    cyc();
    bus_if.mem_ready = 1'($urandom);
    bus_if.resume    = 1'($urandom);
    #1;
    check_w({tag, "/decode"}, w_state(0, 0, 0, 0));
    cyc();
    bus_if.Z = z;
    bus_if.C = c;
    bus_if.mem_ready = 1'($urandom);
    #1;
    check_w({tag, "/exec"}, exp_exec);
    cyc();
    model_count = (model_count + 1) % (1 << CNT_W);
    check_cnt({tag, "/count"});
    $display("instr %s op=%h z=%0d c=%0d wait=%0d count=%0d", tag, op, z, c,
             nwait, bus_if.instr_count);
  endtask

  task automatic do_reset(input string tag);
    CLB = 1'b0;
    cyc();
    CLB = 1'b1;
    #1;
    model_count = 0;
    check_w({tag, "/boot"}, w_state(0, 0, 0, 0));
    check_cnt({tag, "/boot_cnt"});
    cyc();
  endtask

  initial begin
    int saved;
    logic [5:0] rop;
    bit rz, rc;

    vecs[0]  = '{6'h00, 1'b1, 1'b1, ex(0, 2'b00, 4'h0, 0, 0)};
    vecs[1]  = '{6'h01, 1'b0, 1'b0, ex(1, 2'b01, 4'h0, 0, 0)};
    vecs[2]  = '{6'h02, 1'b0, 1'b0, ex(0, 2'b00, 4'h0, 1, 0)};
    vecs[3]  = '{6'h03, 1'b1, 1'b0, ex(1, 2'b10, 4'h0, 0, 0)};
    vecs[4]  = '{6'h04, 1'b0, 1'b1, ex(1, 2'b00, 4'h4, 0, 0)};
    vecs[5]  = '{6'h05, 1'b0, 1'b0, ex(1, 2'b00, 4'h5, 0, 0)};
    vecs[6]  = '{6'h06, 1'b1, 1'b1, ex(1, 2'b00, 4'h6, 0, 0)};
    vecs[7]  = '{6'h07, 1'b0, 1'b0, ex(1, 2'b00, 4'h7, 0, 0)};
    vecs[8]  = '{6'h08, 1'b0, 1'b0, ex(1, 2'b00, 4'h8, 0, 0)};
    vecs[9]  = '{6'h09, 1'b1, 1'b0, ex(1, 2'b00, 4'h9, 0, 0)};
    vecs[10] = '{6'h0A, 1'b0, 1'b0, ex(1, 2'b00, 4'hA, 0, 0)};
    vecs[11] = '{6'h0B, 1'b0, 1'b1, ex(1, 2'b00, 4'hB, 0, 0)};
    vecs[12] = '{6'h0C, 1'b0, 1'b0, ex(0, 2'b00, 4'h0, 0, 1)};
    vecs[13] = '{6'h0C, 1'b1, 1'b1, ex(0, 2'b00, 4'h0, 0, 1)};
    vecs[14] = '{6'h0D, 1'b0, 1'b1, ex(0, 2'b00, 4'h0, 0, 0)};
    vecs[15] = '{6'h0D, 1'b1, 1'b0, ex(0, 2'b00, 4'h0, 0, 1)};
    vecs[16] = '{6'h0E, 1'b1, 1'b0, ex(0, 2'b00, 4'h0, 0, 0)};
    vecs[17] = '{6'h0E, 1'b0, 1'b1, ex(0, 2'b00, 4'h0, 0, 1)};

    CLB = 1'b0;
    bus_if.Opcode = '0;
    bus_if.Z = 1'b0;
    bus_if.C = 1'b0;
    bus_if.mem_ready = 1'b0;
    bus_if.resume = 1'b0;

    // Reset held three cycles, then BOOT, then FETCH.
    repeat (3) cyc();
    #1;
    check_w("rst/hold", w_state(0, 0, 0, 0));
    CLB = 1'b1;
    #1;
    check_w("rst/boot", w_state(0, 0, 0, 0));
    check_cnt("rst/count");
    cyc();
    bus_if.mem_ready = 1'b0;
    #1;
    check_w("rst/fetch", w_state(1, 0, 0, 0));
    cyc();
    run_instr(6'h04, 1'b0, 1'b0, 1, ex(1, 2'b00, 4'h4, 0, 0), "add_wait2");

    for (int i = 0; i < 18; i++)
      run_instr(vecs[i].op, vecs[i].z, vecs[i].c, i % 3, vecs[i].exp,
                $sformatf("vec%0d", i));

    // HLT: halted until resume, no retire.
    bus_if.mem_ready = 1'b1;
    bus_if.Opcode = 6'h0F;
    #1;
    check_w("hlt/fetch", w_state(1, 1, 0, 0));
    cyc();
    bus_if.resume = 1'b0;
    #1;
    check_w("hlt/decode", w_state(0, 0, 0, 0));
    cyc();
    #1;
    check_w("hlt/halt1", w_state(0, 0, 1, 0));
    cyc();
    #1;
    check_w("hlt/halt2", w_state(0, 0, 1, 0));
    bus_if.resume = 1'b1;
    #1;
    check_w("hlt/halt_resume", w_state(0, 0, 1, 0));
    cyc();
    bus_if.resume = 1'b0;
    bus_if.mem_ready = 1'b0;
    #1;
    check_w("hlt/refetch", w_state(1, 0, 0, 0));
    check_cnt("hlt/count");
    $display("instr hlt op=0f count=%0d", bus_if.instr_count);
    cyc();

    for (int i = 0; i < 40; i++) begin
      rop = 6'($urandom_range(0, 14));
      rz  = 1'($urandom);
      rc  = 1'($urandom);
      run_instr(rop, rz, rc, $urandom_range(0, 5), model_exec(int'(rop), rz, rc),
                $sformatf("rnd%0d", i));
    end

    // Sixteen retirements wrap the 4-bit counter back to its start value.
    saved = int'(bus_if.instr_count);
    for (int i = 0; i < 16; i++)
      run_instr(6'h00, 1'b0, 1'b0, $urandom_range(0, 2), ex(0, 2'b00, 4'h0, 0, 0),
                $sformatf("wrap%0d", i));
    n_checks++;
    if (int'(bus_if.instr_count) != saved) begin
      n_errors++;
      $display("FAIL wrap/count: instr_count got %0d expected %0d",
               bus_if.instr_count, saved);
    end

    // Illegal opcode goes to FAULT and stays there.
    bus_if.mem_ready = 1'b1;
    bus_if.Opcode = 6'h14;
    #1;
    check_w("ill/fetch", w_state(1, 1, 0, 0));
    cyc();
    #1;
    check_w("ill/decode", w_state(0, 0, 0, 0));
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus_if.resume = 1'b1;
      #1;
      check_w($sformatf("ill/fault%0d", i), w_state(0, 0, 0, 1));
      cyc();
    end
    check_cnt("ill/count");
    $display("instr illegal op=14 fault=%0d", bus_if.fault);
    bus_if.resume = 1'b0;
    do_reset("ill_rst");

    // Fetch timeout after MAX_WAIT idle cycles.
    for (int i = 0; i < MAX_WAIT; i++) begin
      bus_if.mem_ready = 1'b0;
      #1;
      check_w($sformatf("to/wait%0d", i), w_state(1, 0, 0, 0));
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      bus_if.mem_ready = 1'b1;
      #1;
      check_w($sformatf("to/fault%0d", i), w_state(0, 0, 0, 1));
      cyc();
    end
    $display("instr timeout fault=%0d", bus_if.fault);
    do_reset("to_rst");

    // Reset mid-wait must clear the wait counter.
    for (int i = 0; i < 10; i++) begin
      bus_if.mem_ready = 1'b0;
      #1;
      check_w($sformatf("mid/wait%0d", i), w_state(1, 0, 0, 0));
      cyc();
    end
    do_reset("mid_rst");
    run_instr(6'h00, 1'b0, 1'b0, MAX_WAIT - 1, ex(0, 2'b00, 4'h0, 0, 0), "mid_post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
